// File: rtl/bp_be_pipe_sys_mt_pkg.sv
// Shared definitions for the multi-thread BE system pipe: CSR addresses, funct3 codes,
// the staging entry layout and the context-switch state type.
package bp_be_pkg;

    localparam logic [11:0] bp_csr_ctxt_gp     = 12'h081;
    localparam logic [11:0] bp_csr_tscratch_gp = 12'h5C0;
    localparam logic [11:0] bp_csr_tswcnt_gp   = 12'hC81;

    localparam logic [2:0] bp_csrrw_gp  = 3'b001;
    localparam logic [2:0] bp_csrrs_gp  = 3'b010;
    localparam logic [2:0] bp_csrrc_gp  = 3'b011;
    localparam logic [2:0] bp_csrrwi_gp = 3'b101;
    localparam logic [2:0] bp_csrrsi_gp = 3'b110;
    localparam logic [2:0] bp_csrrci_gp = 3'b111;

    // Staging entries are sized for the widest supported configuration
    localparam int bp_be_sys_tid_max_gp   = 8;
    localparam int bp_be_sys_dword_max_gp = 64;

    typedef enum logic [1:0] {
        e_ctxt_idle = 2'b00,
        e_ctxt_req  = 2'b01,
        e_ctxt_swap = 2'b10
    } bp_be_sys_ctxt_state_e;

    typedef struct packed {
        logic                              v;
        logic [bp_be_sys_tid_max_gp-1:0]   tid;
        logic [2:0]                        funct3;
        logic [11:0]                       addr;
        logic [bp_be_sys_dword_max_gp-1:0] src;
    } bp_be_sys_stage_s;

    // RW variants always write; set/clear variants write only with a nonzero source
    function automatic logic csr_write_intent(input logic [2:0] funct3, input logic src_nz);
        logic wi;
        case (funct3[1:0])
            2'b01:        wi = 1'b1;
            2'b10, 2'b11: wi = src_nz;
            default:      wi = 1'b0;
        endcase
        return wi;
    endfunction

endpackage

// File: rtl/bp_be_pipe_sys_mt_if.sv
// Issue-side bus of the multi-thread system pipe: CSR op in, read data and hit/illegal status out.
interface bp_be_pipe_sys_mt_if #(
    parameter int threads_p     = 2,
    parameter int dword_width_p = 64
);
    localparam int tid_width_lp = (threads_p > 1) ? $clog2(threads_p) : 1;

    logic                     issue_v_i;
    logic                     issue_ready_o;
    logic [tid_width_lp-1:0]  issue_tid_i;
    logic [2:0]               issue_funct3_i;
    logic [11:0]              issue_addr_i;
    logic [dword_width_p-1:0] issue_rs1_i;
    logic [4:0]               issue_zimm_i;
    logic                     v_o;
    logic                     illegal_o;
    logic [dword_width_p-1:0] data_o;

    modport master (
        output issue_v_i, issue_tid_i, issue_funct3_i, issue_addr_i, issue_rs1_i, issue_zimm_i,
        input  issue_ready_o, v_o, illegal_o, data_o
    );

    modport slave (
        input  issue_v_i, issue_tid_i, issue_funct3_i, issue_addr_i, issue_rs1_i, issue_zimm_i,
        output issue_ready_o, v_o, illegal_o, data_o
    );

endinterface

// File: rtl/bp_be_pipe_sys_mt_stage.sv
// Fixed-latency valid/payload shift register; flush clears every valid bit, including the incoming one.
module bp_be_sys_stage_pipe #(
    parameter int depth_p = 2,
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    logic [depth_p-1:0] v_r;
    logic [width_p-1:0] data_r [depth_p];

    // Advance valid bits and payload one slot per cycle
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_r <= {depth_p{1'b0}};
            for (int i = 0; i < depth_p; i++) data_r[i] <= {width_p{1'b0}};
        end else begin
            if (flush_i) begin
                v_r <= {depth_p{1'b0}};
            end else begin
                v_r[0] <= v_i;
                for (int i = 1; i < depth_p; i++) v_r[i] <= v_r[i-1];
            end
            data_r[0] <= data_i;
            for (int i = 1; i < depth_p; i++) data_r[i] <= data_r[i-1];
        end
    end

    assign v_o    = v_r[depth_p-1];
    assign data_o = data_r[depth_p-1];

endmodule

// File: rtl/bp_be_pipe_sys_mt.sv
// Multi-thread BE system pipe: thread-banked CSRs, retire-staged writes and the CTXT switch handshake.
// Defining BP_BE_SYS_MT_PERF_EN adds the read-only per-thread TSWCNT switch counters at 0xC81.
module bp_be_pipe_sys_mt
    import bp_be_pkg::*;
#(
    parameter  int threads_p      = 2,
    parameter  int retire_depth_p = 2,
    parameter  int dword_width_p  = 64,
    localparam int tid_width_lp   = (threads_p > 1) ? $clog2(threads_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    bp_be_pipe_sys_mt_if.slave      issue_if,
    input  logic                    flush_i,
    input  logic                    retire_v_i,
    input  logic                    retire_exception_i,
    output logic [tid_width_lp-1:0] current_tid_o,
    output logic                    switch_req_o,
    output logic [tid_width_lp-1:0] switch_tid_o,
    input  logic                    switch_ack_i,
    output logic                    err_o
);

    localparam int payload_w_lp = $bits(bp_be_sys_stage_s) - 1;

    function automatic logic tid_valid(input logic [tid_width_lp-1:0] tid);
        return (32'(tid) < threads_p);
    endfunction

    bp_be_sys_ctxt_state_e    state_r;
    logic [tid_width_lp-1:0]  current_tid_r, switch_tid_r;
    logic                     switch_req_r, issue_ready_r, err_r;
    logic [dword_width_p-1:0] tscratch_r [threads_p];
`ifdef BP_BE_SYS_MT_PERF_EN
    logic [31:0]              tswcnt_r [threads_p];
`endif

    logic                     issue_fire_s, hit_s, ro_s, wi_s, illegal_s;
    logic [dword_width_p-1:0] issue_src_s, rdata_s;
    bp_be_sys_stage_s         stage_in_s, tail_s;
    logic                     tail_v_s;
    logic [payload_w_lp-1:0]  tail_payload_s;

    // Issue decode: hit/read-only lookup, write intent and combinational read data
    always_comb begin
        issue_fire_s = issue_if.issue_v_i & issue_ready_r;
        issue_src_s  = issue_if.issue_funct3_i[2] ? dword_width_p'(issue_if.issue_zimm_i)
                                                  : issue_if.issue_rs1_i;
        wi_s    = csr_write_intent(issue_if.issue_funct3_i, |issue_src_s);
        hit_s   = 1'b0;
        ro_s    = 1'b0;
        rdata_s = {dword_width_p{1'b0}};
        case (issue_if.issue_addr_i)
            bp_csr_ctxt_gp: begin
                hit_s   = 1'b1;
                rdata_s = dword_width_p'(current_tid_r);
            end
            bp_csr_tscratch_gp: begin
                hit_s = 1'b1;
                if (tid_valid(issue_if.issue_tid_i)) rdata_s = tscratch_r[issue_if.issue_tid_i];
                else                                 rdata_s = {dword_width_p{1'b0}};
            end
`ifdef BP_BE_SYS_MT_PERF_EN
            bp_csr_tswcnt_gp: begin
                hit_s = 1'b1;
                ro_s  = 1'b1;
                if (tid_valid(issue_if.issue_tid_i)) rdata_s = dword_width_p'(tswcnt_r[issue_if.issue_tid_i]);
                else                                 rdata_s = {dword_width_p{1'b0}};
            end
`endif
            default: begin
                hit_s = 1'b0;
            end
        endcase
        illegal_s          = issue_fire_s & (~hit_s | (wi_s & ro_s));
        issue_if.v_o       = issue_fire_s & ~illegal_s;
        issue_if.illegal_o = illegal_s;
        issue_if.data_o    = issue_fire_s ? rdata_s : {dword_width_p{1'b0}};
        stage_in_s.v       = issue_fire_s & ~illegal_s & wi_s;
        stage_in_s.tid     = bp_be_sys_tid_max_gp'(issue_if.issue_tid_i);
        stage_in_s.funct3  = issue_if.issue_funct3_i;
        stage_in_s.addr    = issue_if.issue_addr_i;
        stage_in_s.src     = bp_be_sys_dword_max_gp'(issue_src_s);
    end

    assign issue_if.issue_ready_o = issue_ready_r;

    bp_be_sys_stage_pipe #(
        .depth_p (retire_depth_p),
        .width_p (payload_w_lp)
    ) stage_pipe (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .v_i     (stage_in_s.v),
        .data_i  (stage_in_s[payload_w_lp-1:0]),
        .v_o     (tail_v_s),
        .data_o  (tail_payload_s)
    );

    assign tail_s = {tail_v_s, tail_payload_s};

    logic                     commit_s, ctxt_commit_s, ctxt_switch_s, tscratch_commit_s;
    logic [tid_width_lp-1:0]  tail_tid_s, ctxt_new_tid_s;
    logic [dword_width_p-1:0] tail_src_s, old_s, new_s;

    // Commit: read-modify-write against the CSR value as it stands at retire
    always_comb begin
        commit_s   = retire_v_i & ~retire_exception_i & tail_s.v;
        tail_tid_s = tid_width_lp'(tail_s.tid);
        tail_src_s = dword_width_p'(tail_s.src);
        if (tail_s.addr == bp_csr_ctxt_gp)                               old_s = dword_width_p'(current_tid_r);
        else if (tail_s.addr == bp_csr_tscratch_gp && tid_valid(tail_tid_s)) old_s = tscratch_r[tail_tid_s];
        else                                                             old_s = {dword_width_p{1'b0}};
        case (tail_s.funct3[1:0])
            2'b01:   new_s = tail_src_s;
            2'b10:   new_s = old_s | tail_src_s;
            2'b11:   new_s = old_s & ~tail_src_s;
            default: new_s = old_s;
        endcase
        ctxt_new_tid_s    = new_s[tid_width_lp-1:0];
        ctxt_commit_s     = commit_s & (tail_s.addr == bp_csr_ctxt_gp);
        ctxt_switch_s     = ctxt_commit_s & tid_valid(ctxt_new_tid_s) & (ctxt_new_tid_s != current_tid_r);
        tscratch_commit_s = commit_s & (tail_s.addr == bp_csr_tscratch_gp) & tid_valid(tail_tid_s);
    end

    // Context-switch FSM with its registered handshake outputs and the sticky drop error
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r       <= e_ctxt_idle;
            current_tid_r <= {tid_width_lp{1'b0}};
            switch_tid_r  <= {tid_width_lp{1'b0}};
            switch_req_r  <= 1'b0;
            issue_ready_r <= 1'b1;
            err_r         <= 1'b0;
        end else begin
            if (ctxt_commit_s && (state_r != e_ctxt_idle)) err_r <= 1'b1;
            else                                           err_r <= err_r;
            case (state_r)
                e_ctxt_idle: begin
                    if (ctxt_switch_s) begin
                        state_r       <= e_ctxt_req;
                        switch_tid_r  <= ctxt_new_tid_s;
                        switch_req_r  <= 1'b1;
                        issue_ready_r <= 1'b0;
                    end
                end
                e_ctxt_req: begin
                    if (switch_ack_i) begin
                        state_r      <= e_ctxt_swap;
                        switch_req_r <= 1'b0;
                    end
                end
                e_ctxt_swap: begin
                    current_tid_r <= switch_tid_r;
                    state_r       <= e_ctxt_idle;
                    issue_ready_r <= 1'b1;
                end
                default: begin
                    state_r       <= e_ctxt_idle;
                    switch_req_r  <= 1'b0;
                    issue_ready_r <= 1'b1;
                end
            endcase
        end
    end

    // Thread-banked scratch registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < threads_p; i++) tscratch_r[i] <= {dword_width_p{1'b0}};
        end else if (tscratch_commit_s) begin
            tscratch_r[tail_tid_s] <= new_s;
        end else begin
            tscratch_r[0] <= tscratch_r[0];
        end
    end

`ifdef BP_BE_SYS_MT_PERF_EN
    // Switch counters: bump the destination thread once per completed swap
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < threads_p; i++) tswcnt_r[i] <= 32'd0;
        end else if (state_r == e_ctxt_swap) begin
            tswcnt_r[switch_tid_r] <= tswcnt_r[switch_tid_r] + 32'd1;
        end else begin
            tswcnt_r[0] <= tswcnt_r[0];
        end
    end
`endif

    assign current_tid_o = current_tid_r;
    assign switch_req_o  = switch_req_r;
    assign switch_tid_o  = switch_tid_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_bp_be_pipe_sys_mt.sv
// Bench for bp_be_pipe_sys_mt: directed scenarios plus random traffic against a queue-based model.
module tb_bp_be_pipe_sys_mt;
    import bp_be_pkg::*;

    localparam int T  = 2;
    localparam int D  = 2;
    localparam int W  = 64;
    localparam int TW = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0, retire_v = 1'b0, retire_exc = 1'b0, ack = 1'b0;
    logic [TW-1:0] cur, stid;
    logic sreq, err;

    always #5 clk = ~clk;

    bp_be_pipe_sys_mt_if #(.threads_p(T), .dword_width_p(W)) bus ();

    bp_be_pipe_sys_mt #(.threads_p(T), .retire_depth_p(D), .dword_width_p(W)) dut (
        .clk_i(clk), .reset_i(rst), .issue_if(bus), .flush_i(flush), .retire_v_i(retire_v),
        .retire_exception_i(retire_exc), .current_tid_o(cur), .switch_req_o(sreq),
        .switch_tid_o(stid), .switch_ack_i(ack), .err_o(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          t;
        int          tid;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [63:0] src;
    } op_t;

    logic [63:0] m_bank [T];
    logic [31:0] m_cnt [T];
    int  m_cur = 0, m_tgt = 0, cyc = 0;
    bit  m_req = 0, m_swap = 0, m_err = 0;
    op_t q[$];

    function automatic logic [63:0] cur_src();
        return bus.issue_funct3_i[2] ? {59'd0, bus.issue_zimm_i} : bus.issue_rs1_i;
    endfunction

    function automatic void m_issue(output bit v, output bit ill, output logic [63:0] data, output bit stg);
        bit fire, hit, ro, wi;
        int tid;
        fire = bus.issue_v_i && !m_req && !m_swap;
        tid  = int'(bus.issue_tid_i);
        wi   = (bus.issue_funct3_i[1:0] == 2'b01) || (cur_src() != 64'd0);
        hit = 0; ro = 0; data = 64'd0;
        if (bus.issue_addr_i == 12'h081) begin hit = 1; data = 64'(m_cur); end
        else if (bus.issue_addr_i == 12'h5C0) begin hit = 1; data = m_bank[tid]; end
`ifdef BP_BE_SYS_MT_PERF_EN
        else if (bus.issue_addr_i == 12'hC81) begin hit = 1; ro = 1; data = {32'd0, m_cnt[tid]}; end
`endif
        ill = fire && (!hit || (wi && ro));
        v   = fire && !ill;
        if (!fire) data = 64'd0;
        stg = v && wi;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < T; i++) begin m_bank[i] = 64'd0; m_cnt[i] = 32'd0; end
        m_cur = 0; m_tgt = 0; m_req = 0; m_swap = 0; m_err = 0; cyc = 0;
        q.delete();
    endtask

    initial begin
        bit v, ill, stg, was_req, was_swap;
        logic [63:0] d, old, nv;
        int idx, nt;
        op_t o;
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else begin
                m_issue(v, ill, d, stg);
                was_req = m_req; was_swap = m_swap;
                idx = -1;
                for (int i = 0; i < q.size(); i++) if (q[i].t == cyc - D) idx = i;
                if (retire_v && !retire_exc && idx >= 0) begin
                    o = q[idx];
                    old = (o.addr == 12'h081) ? 64'(m_cur) : m_bank[o.tid];
                    if (o.f3[1:0] == 2'b01)      nv = o.src;
                    else if (o.f3[1:0] == 2'b10) nv = old | o.src;
                    else                         nv = old & ~o.src;
                    if (o.addr == 12'h081) begin
                        nt = int'(nv) & ((1 << TW) - 1);
                        if (was_req || was_swap) m_err = 1;
                        else if (nt < T && nt != m_cur) begin m_req = 1; m_tgt = nt; end
                    end else begin
                        m_bank[o.tid] = nv;
                    end
                end
                if (was_swap) begin m_cur = m_tgt; m_swap = 0; m_cnt[m_tgt] = m_cnt[m_tgt] + 32'd1; end
                if (was_req && ack) begin m_req = 0; m_swap = 1; end
                if (flush) q.delete();
                else begin
                    while (q.size() > 0 && q[0].t <= cyc - D) void'(q.pop_front());
                    if (stg) begin
                        o.t = cyc; o.tid = int'(bus.issue_tid_i); o.f3 = bus.issue_funct3_i;
                        o.addr = bus.issue_addr_i; o.src = cur_src();
                        q.push_back(o);
                    end
                end
                cyc++;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    initial begin
        bit v, ill, stg;
        logic [63:0] d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_issue(v, ill, d, stg);
                chk("v_o", 64'(bus.v_o), 64'(v));
                chk("illegal_o", 64'(bus.illegal_o), 64'(ill));
                chk("data_o", bus.data_o, d);
                chk("issue_ready_o", 64'(bus.issue_ready_o), 64'(!m_req && !m_swap));
                chk("current_tid_o", 64'(cur), 64'(m_cur));
                chk("switch_req_o", 64'(sreq), 64'(m_req));
                chk("err_o", 64'(err), 64'(m_err));
                if (m_req) chk("switch_tid_o", 64'(stid), 64'(m_tgt));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.issue_v_i = 1'b0; bus.issue_tid_i = '0; bus.issue_funct3_i = 3'd0;
        bus.issue_addr_i = 12'd0; bus.issue_rs1_i = 64'd0; bus.issue_zimm_i = 5'd0;
        flush = 1'b0; retire_v = 1'b0; retire_exc = 1'b0;
    endtask

    task automatic issue(input int tid, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [63:0] rs1, input logic [4:0] zimm);
        bus.issue_v_i = 1'b1; bus.issue_tid_i = TW'(tid); bus.issue_funct3_i = f3;
        bus.issue_addr_i = addr; bus.issue_rs1_i = rs1; bus.issue_zimm_i = zimm;
    endtask

    // Side-effect-free peek: CSRRS with rs1=0 held only between edges
    task automatic read_csr(input int tid, input logic [11:0] addr, output logic [63:0] data);
        issue(tid, bp_csrrs_gp, addr, 64'd0, 5'd0);
        #1;
        data = bus.data_o;
        bus.issue_v_i = 1'b0;
    endtask

    logic [2:0]  f3_tab [6];
    logic [11:0] addr_tab [3];

    initial begin
        logic [63:0] rd;
        f3_tab[0] = bp_csrrw_gp;  f3_tab[1] = bp_csrrs_gp;  f3_tab[2] = bp_csrrc_gp;
        f3_tab[3] = bp_csrrwi_gp; f3_tab[4] = bp_csrrsi_gp; f3_tab[5] = bp_csrrci_gp;
        addr_tab[0] = 12'h081; addr_tab[1] = 12'h5C0; addr_tab[2] = 12'hC81;
        clear_in();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_ready", 64'(bus.issue_ready_o), 64'd1);
        chk("reset_req", 64'(sreq), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_tid", 64'(cur), 64'd0);

        // TSCRATCH RW 0xDEAD on tid1, retire two cycles later
        issue(1, bp_csrrw_gp, 12'h5C0, 64'hDEAD, 5'd0);
        #1;
        chk("t1_data", bus.data_o, 64'd0);
        chk("t1_v", 64'(bus.v_o), 64'd1);
        tick(); clear_in(); tick();
        retire_v = 1'b1; tick(); retire_v = 1'b0;
        read_csr(1, 12'h5C0, rd); chk("t1_bank1", rd, 64'hDEAD);
        read_csr(0, 12'h5C0, rd); chk("t1_bank0", rd, 64'd0);

        // TSWCNT access
        issue(0, bp_csrrsi_gp, 12'hC81, 64'd0, 5'd0);
        #1;
`ifdef BP_BE_SYS_MT_PERF_EN
        chk("tswcnt_rsi_v", 64'(bus.v_o), 64'd1);
        chk("tswcnt_rsi_ill", 64'(bus.illegal_o), 64'd0);
`else
        chk("tswcnt_miss_ill", 64'(bus.illegal_o), 64'd1);
        chk("tswcnt_miss_v", 64'(bus.v_o), 64'd0);
`endif
        issue(0, bp_csrrw_gp, 12'hC81, 64'd5, 5'd0);
        #1;
        chk("tswcnt_rw_ill", 64'(bus.illegal_o), 64'd1);
        bus.issue_v_i = 1'b0;

        // CTXT switch 0 -> 1 with a delayed ack
        tick();
        issue(0, bp_csrrw_gp, 12'h081, 64'd1, 5'd0);
        tick(); clear_in(); tick();
        retire_v = 1'b1; tick(); retire_v = 1'b0;
        chk("sw_req", 64'(sreq), 64'd1);
        chk("sw_tid", 64'(stid), 64'd1);
        chk("sw_ready", 64'(bus.issue_ready_o), 64'd0);
        tick(); tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("swap_ready", 64'(bus.issue_ready_o), 64'd0);
        chk("swap_req", 64'(sreq), 64'd0);
        tick();
        chk("sw_cur", 64'(cur), 64'd1);
        chk("sw_ready_back", 64'(bus.issue_ready_o), 64'd1);
`ifdef BP_BE_SYS_MT_PERF_EN
        read_csr(1, 12'hC81, rd); chk("tswcnt1", rd, 64'd1);
`endif

        // RS 0x0F then RC 0x03 back-to-back -> 0x0C
        tick();
        issue(0, bp_csrrs_gp, 12'h5C0, 64'h0F, 5'd0); tick();
        issue(0, bp_csrrc_gp, 12'h5C0, 64'h03, 5'd0); tick();
        clear_in(); retire_v = 1'b1; tick(); tick(); retire_v = 1'b0;
        read_csr(0, 12'h5C0, rd); chk("rs_rc", rd, 64'h0C);

        // Flushed op and excepting op leave the bank alone
        tick();
        issue(0, bp_csrrw_gp, 12'h5C0, 64'h55, 5'd0); tick();
        clear_in(); flush = 1'b1; tick(); flush = 1'b0;
        retire_v = 1'b1; tick(); retire_v = 1'b0;
        read_csr(0, 12'h5C0, rd); chk("flush_nowrite", rd, 64'h0C);
        tick();
        issue(0, bp_csrrw_gp, 12'h5C0, 64'h77, 5'd0); tick();
        clear_in(); tick();
        retire_v = 1'b1; retire_exc = 1'b1; tick(); clear_in();
        read_csr(0, 12'h5C0, rd); chk("exc_nowrite", rd, 64'h0C);

        // Second CTXT write committing during REQ is dropped and flagged
        tick();
        issue(1, bp_csrrw_gp, 12'h081, 64'd0, 5'd0); tick();
        issue(1, bp_csrrw_gp, 12'h081, 64'd1, 5'd0); tick();
        clear_in(); retire_v = 1'b1; tick(); tick(); retire_v = 1'b0;
        chk("drop_err", 64'(err), 64'd1);
        chk("drop_req", 64'(sreq), 64'd1);
        chk("drop_tid", 64'(stid), 64'd0);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        chk("drop_cur", 64'(cur), 64'd0);

        // Reset in the middle of a switch
        issue(0, bp_csrrwi_gp, 12'h081, 64'd0, 5'd1); tick();
        clear_in(); tick();
        retire_v = 1'b1; tick(); retire_v = 1'b0;
        chk("mid_req", 64'(sreq), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        chk("mid_rst_cur", 64'(cur), 64'd0);
        chk("mid_rst_req", 64'(sreq), 64'd0);
        chk("mid_rst_ready", 64'(bus.issue_ready_o), 64'd1);
        chk("mid_rst_err", 64'(err), 64'd0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            bus.issue_v_i      = 1'($urandom % 2);
            bus.issue_tid_i    = TW'($urandom % T);
            bus.issue_funct3_i = f3_tab[$urandom % 6];
            bus.issue_addr_i   = ($urandom % 8 == 0) ? 12'($urandom) : addr_tab[$urandom % 3];
            if ($urandom % 4 == 0)                   bus.issue_rs1_i = 64'd0;
            else if (bus.issue_addr_i == 12'h081)    bus.issue_rs1_i = 64'($urandom % 4);
            else                                     bus.issue_rs1_i = {32'($urandom), 32'($urandom)};
            bus.issue_zimm_i = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
            retire_v   = ($urandom % 4 != 0);
            retire_exc = ($urandom % 8 == 0);
            flush      = ($urandom % 16 == 0);
            ack        = ($urandom % 3 == 0);
            rst        = (i == 1000);
            tick();
        end
        rst = 1'b0;
        clear_in(); ack = 1'b1;
        tick(); tick(); tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
